// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: memory op codes, FSM states and op decode helpers.
package mem_access_pkg;

  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_LB   = 4'd1;
  localparam logic [3:0] MEM_LBU  = 4'd2;
  localparam logic [3:0] MEM_LH   = 4'd3;
  localparam logic [3:0] MEM_LHU  = 4'd4;
  localparam logic [3:0] MEM_LW   = 4'd5;
  localparam logic [3:0] MEM_SB   = 4'd6;
  localparam logic [3:0] MEM_SH   = 4'd7;
  localparam logic [3:0] MEM_SW   = 4'd8;

  localparam logic [4:0] NOP_REG_ADDR = 5'd0;

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  function automatic logic is_load_op(input logic [3:0] op);
    return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) || (op == MEM_LHU) ||
           (op == MEM_LW);
  endfunction

  function automatic logic is_store_op(input logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
    unique case (op)
      MEM_LH, MEM_LHU, MEM_SH: return addr_lo[0];
      MEM_LW, MEM_SW:          return |addr_lo;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Big-endian lane handling: load byte/half extraction with extension, store lane replication
// and byte-select generation.
module mem_align
  import mem_access_pkg::*;
(
  input  logic [3:0]  memop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] sdata,
  output logic [31:0] ldata,
  output logic [31:0] wdata,
  output logic [3:0]  sel
);

  logic [7:0]  lbyte;
  logic [15:0] lhalf;

  // Lane 0 (addr_lo == 0) is the most significant byte.
  always_comb begin
    unique case (addr_lo)
      2'd0:    lbyte = rdata[31:24];
      2'd1:    lbyte = rdata[23:16];
      2'd2:    lbyte = rdata[15:8];
      default: lbyte = rdata[7:0];
    endcase
    lhalf = addr_lo[1] ? rdata[15:0] : rdata[31:16];
  end

  always_comb begin
    ldata = rdata;
    wdata = 32'h0;
    sel   = 4'b0000;
    unique case (memop)
      MEM_LB: begin
        ldata = {{24{lbyte[7]}}, lbyte};
        sel   = 4'b1000 >> addr_lo;
      end
      MEM_LBU: begin
        ldata = {24'h0, lbyte};
        sel   = 4'b1000 >> addr_lo;
      end
      MEM_LH: begin
        ldata = {{16{lhalf[15]}}, lhalf};
        sel   = addr_lo[1] ? 4'b0011 : 4'b1100;
      end
      MEM_LHU: begin
        ldata = {16'h0, lhalf};
        sel   = addr_lo[1] ? 4'b0011 : 4'b1100;
      end
      MEM_LW: sel = 4'b1111;
      MEM_SB: begin
        wdata = {4{sdata[7:0]}};
        sel   = 4'b1000 >> addr_lo;
      end
      MEM_SH: begin
        wdata = {2{sdata[15:0]}};
        sel   = addr_lo[1] ? 4'b0011 : 4'b1100;
      end
      MEM_SW: begin
        wdata = sdata;
        sel   = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: runs loads/stores over a req/ack data bus with an ack timeout, stalls
// the pipeline while the access is outstanding and forwards results to mem_wb.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned TO_W        = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [4:0]  rw_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  memop_i,
  input  logic [31:0] maddr_i,
  input  logic [31:0] sdata_i,
  output logic [4:0]  rw_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stall_req_o,
  output logic        excpt_o,
  output logic        bus_err_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_sel_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i
);

  localparam logic [TO_W-1:0] TimeoutVal = TO_W'(ACK_TIMEOUT);

  state_e          state_q, state_d;
  logic            req_q, req_d, we_q, we_d, err_q, err_d;
  logic [31:0]     addr_q, addr_d, wdata_q, wdata_d, ldata_q, ldata_d;
  logic [3:0]      sel_q, sel_d;
  logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;

  logic        is_load, is_store, is_mem, misalign, issue;
  logic [31:0] al_ldata, al_wdata;
  logic [3:0]  al_sel;

  assign is_load  = is_load_op(memop_i);
  assign is_store = is_store_op(memop_i);
  assign is_mem   = is_load | is_store;
  assign misalign = is_mem & is_misaligned(memop_i, maddr_i[1:0]);
  assign issue    = is_mem & ~misalign & ~flush_i;
  assign cnt_inc  = cnt_q + TO_W'(1);

  mem_align u_mem_align (
    .memop   (memop_i),
    .addr_lo (maddr_i[1:0]),
    .rdata   (dbus_rdata_i),
    .sdata   (sdata_i),
    .ldata   (al_ldata),
    .wdata   (al_wdata),
    .sel     (al_sel)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    ldata_d = ldata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          state_d = StReq;
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {maddr_i[31:2], 2'b00};
          sel_d   = al_sel;
          wdata_d = al_wdata;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      StReq: begin
        if (dbus_ack_i) begin
          ldata_d = al_ldata;
          req_d   = 1'b0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TimeoutVal) begin
            req_d   = 1'b0;
            err_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        // Always leave DONE so the same instruction is never re-issued.
        state_d = StIdle;
        err_d   = 1'b0;
        cnt_d   = '0;
      end
      default: state_d = StIdle;
    endcase
    if (flush_i) begin
      state_d = StIdle;
      req_d   = 1'b0;
      err_d   = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      sel_q   <= 4'b0000;
      wdata_q <= 32'h0;
      ldata_q <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      ldata_q <= ldata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    rw_o        = rw_i;
    wreg_o      = 1'b0;
    wdata_o     = wdata_i;
    stall_req_o = 1'b0;
    if (!rst) begin
      rw_o    = NOP_REG_ADDR;
      wdata_o = 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!is_mem)        wreg_o      = wreg_i;
          else if (!misalign) stall_req_o = 1'b1;
        end
        StReq: stall_req_o = 1'b1;
        StDone: begin
          wreg_o  = wreg_i & is_load & ~err_q;
          wdata_o = is_load ? ldata_q : wdata_i;
        end
        default: ;
      endcase
      if (flush_i) stall_req_o = 1'b0;
    end
  end

  assign excpt_o      = rst & misalign;
  assign bus_err_o    = err_q;
  assign dbus_req_o   = req_q;
  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_sel_o   = sel_q;
  assign dbus_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed-vector bench for mem_access with hand-computed expectations.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic [4:0]  rw_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [3:0]  memop_i;
  logic [31:0] maddr_i;
  logic [31:0] sdata_i;
  logic [4:0]  rw_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_req_o;
  logic        excpt_o;
  logic        bus_err_o;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_sel_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_ack_i;
  logic [31:0] dbus_rdata_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access #(.ACK_TIMEOUT(16), .TO_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .rw_i         (rw_i),
    .wreg_i       (wreg_i),
    .wdata_i      (wdata_i),
    .memop_i      (memop_i),
    .maddr_i      (maddr_i),
    .sdata_i      (sdata_i),
    .rw_o         (rw_o),
    .wreg_o       (wreg_o),
    .wdata_o      (wdata_o),
    .stall_req_o  (stall_req_o),
    .excpt_o      (excpt_o),
    .bus_err_o    (bus_err_o),
    .dbus_req_o   (dbus_req_o),
    .dbus_we_o    (dbus_we_o),
    .dbus_addr_o  (dbus_addr_o),
    .dbus_sel_o   (dbus_sel_o),
    .dbus_wdata_o (dbus_wdata_o),
    .dbus_ack_i   (dbus_ack_i),
    .dbus_rdata_i (dbus_rdata_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [4:0] rw, input logic wr);
    memop_i = op;
    maddr_i = addr;
    sdata_i = sd;
    rw_i    = rw;
    wreg_i  = wr;
    wdata_i = 32'h5555_AAAA;
    #1;
  endtask

  // Runs the current access to completion, acking after wait_cycles REQ cycles; returns in DONE.
  task automatic run_access(input int wait_cycles, input logic [31:0] rdata,
                            output int stalls, output int req_cycles,
                            output logic [3:0] cap_sel, output logic cap_we,
                            output logic [31:0] cap_addr, output logic [31:0] cap_wdata);
    stalls     = 0;
    req_cycles = 0;
    cap_sel    = 4'h0;
    cap_we     = 1'b0;
    cap_addr   = 32'h0;
    cap_wdata  = 32'h0;
    for (int i = 0; i < 40 && stall_req_o; i++) begin
      stalls++;
      if (dbus_req_o) begin
        if (req_cycles == 0) begin
          cap_sel   = dbus_sel_o;
          cap_we    = dbus_we_o;
          cap_addr  = dbus_addr_o;
          cap_wdata = dbus_wdata_o;
        end
        if (req_cycles == wait_cycles) begin
          dbus_ack_i   = 1'b1;
          dbus_rdata_i = rdata;
        end
        req_cycles++;
      end
      step();
      dbus_ack_i = 1'b0;
    end
  endtask

  int          stalls, reqs;
  logic [3:0]  c_sel;
  logic        c_we;
  logic [31:0] c_addr, c_wdata;

  initial begin
    rst          = 1'b0;
    flush_i      = 1'b0;
    dbus_ack_i   = 1'b0;
    dbus_rdata_i = 32'h0;
    set_op(MEM_NONE, 32'h0, 32'h0, 5'd3, 1'b1);

    // Reset state
    check("rst_rw", 32'(rw_o), 32'd0);
    check("rst_wreg", 32'(wreg_o), 32'd0);
    check("rst_wdata", wdata_o, 32'h0);
    check("rst_stall", 32'(stall_req_o), 32'd0);
    check("rst_req", 32'(dbus_req_o), 32'd0);
    check("rst_addr", dbus_addr_o, 32'h0);
    check("rst_sel", 32'(dbus_sel_o), 32'd0);
    step();
    rst = 1'b1;
    step();

    // ADD passthrough
    memop_i = MEM_NONE; rw_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h1234;
    #1;
    check("add_rw", 32'(rw_o), 32'd3);
    check("add_wreg", 32'(wreg_o), 32'd1);
    check("add_wdata", wdata_o, 32'h1234);
    check("add_stall", 32'(stall_req_o), 32'd0);
    step();
    check("add_noreq", 32'(dbus_req_o), 32'd0);

    // LB sign-extended, ack on first REQ edge
    set_op(MEM_LB, 32'h103, 32'h0, 5'd7, 1'b1);
    run_access(0, 32'h1122_33F0, stalls, reqs, c_sel, c_we, c_addr, c_wdata);
    check("lb_stalls", 32'(stalls), 32'd2);
    check("lb_sel", 32'(c_sel), 32'h1);
    check("lb_addr", c_addr, 32'h100);
    check("lb_we", 32'(c_we), 32'd0);
    check("lb_wdata", wdata_o, 32'hFFFF_FFF0);
    check("lb_wreg", 32'(wreg_o), 32'd1);
    check("lb_rw", 32'(rw_o), 32'd7);
    check("lb_reqdrop", 32'(dbus_req_o), 32'd0);
    set_op(MEM_NONE, 32'h0, 32'h0, 5'd0, 1'b0);
    step();

    // LBU same address
    set_op(MEM_LBU, 32'h103, 32'h0, 5'd7, 1'b1);
    run_access(0, 32'h1122_33F0, stalls, reqs, c_sel, c_we, c_addr, c_wdata);
    check("lbu_stalls", 32'(stalls), 32'd2);
    check("lbu_wdata", wdata_o, 32'h0000_00F0);
    set_op(MEM_NONE, 32'h0, 32'h0, 5'd0, 1'b0);
    step();

    // LH at half 0, LHU at half 1
    set_op(MEM_LH, 32'h200, 32'h0, 5'd9, 1'b1);
    run_access(1, 32'h8001_7FFF, stalls, reqs, c_sel, c_we, c_addr, c_wdata);
    check("lh_sel", 32'(c_sel), 32'hC);
    check("lh_wdata", wdata_o, 32'hFFFF_8001);
    check("lh_stalls", 32'(stalls), 32'd3);
    set_op(MEM_NONE, 32'h0, 32'h0, 5'd0, 1'b0);
    step();
    set_op(MEM_LHU, 32'h202, 32'h0, 5'd9, 1'b1);
    run_access(0, 32'h8001_F00D, stalls, reqs, c_sel, c_we, c_addr, c_wdata);
    check("lhu_wdata", wdata_o, 32'h0000_F00D);
    set_op(MEM_NONE, 32'h0, 32'h0, 5'd0, 1'b0);
    step();

    // SH, ack after 3 wait cycles
    set_op(MEM_SH, 32'h202, 32'h0000_ABCD, 5'd4, 1'b0);
    run_access(3, 32'h0, stalls, reqs, c_sel, c_we, c_addr, c_wdata);
    check("sh_we", 32'(c_we), 32'd1);
    check("sh_sel", 32'(c_sel), 32'h3);
    check("sh_wdata", c_wdata, 32'hABCD_ABCD);
    check("sh_addr", c_addr, 32'h200);
    check("sh_stalls", 32'(stalls), 32'd5);
    check("sh_wreg", 32'(wreg_o), 32'd0);
    set_op(MEM_NONE, 32'h0, 32'h0, 5'd0, 1'b0);
    step();

    // SB lane 1
    set_op(MEM_SB, 32'h301, 32'h0000_005A, 5'd4, 1'b1);
    run_access(0, 32'h0, stalls, reqs, c_sel, c_we, c_addr, c_wdata);
    check("sb_sel", 32'(c_sel), 32'h4);
    check("sb_wdata", c_wdata, 32'h5A5A_5A5A);
    check("sb_wreg", 32'(wreg_o), 32'd0);
    set_op(MEM_NONE, 32'h0, 32'h0, 5'd0, 1'b0);
    step();

    // Misaligned LW
    set_op(MEM_LW, 32'h101, 32'h0, 5'd5, 1'b1);
    check("mis_excpt", 32'(excpt_o), 32'd1);
    check("mis_wreg", 32'(wreg_o), 32'd0);
    check("mis_stall", 32'(stall_req_o), 32'd0);
    step();
    check("mis_noreq", 32'(dbus_req_o), 32'd0);
    set_op(MEM_NONE, 32'h0, 32'h0, 5'd0, 1'b0);
    check("mis_excpt_clr", 32'(excpt_o), 32'd0);
    step();

    // LW with no ack: timeout
    set_op(MEM_LW, 32'h400, 32'h0, 5'd6, 1'b1);
    run_access(1000, 32'h0, stalls, reqs, c_sel, c_we, c_addr, c_wdata);
    check("to_reqcycles", 32'(reqs), 32'd16);
    check("to_stalls", 32'(stalls), 32'd17);
    check("to_buserr", 32'(bus_err_o), 32'd1);
    check("to_wreg", 32'(wreg_o), 32'd0);
    check("to_reqdrop", 32'(dbus_req_o), 32'd0);
    set_op(MEM_NONE, 32'h0, 32'h0, 5'd2, 1'b1);
    step();
    check("to_buserr_clr", 32'(bus_err_o), 32'd0);
    check("to_idle_wreg", 32'(wreg_o), 32'd1);

    // Flush mid-REQ, then late ack ignored
    set_op(MEM_LW, 32'h500, 32'h0, 5'd6, 1'b1);
    step();
    step();
    check("fl_req", 32'(dbus_req_o), 32'd1);
    flush_i = 1'b1;
    #1;
    check("fl_stall", 32'(stall_req_o), 32'd0);
    step();
    flush_i = 1'b0;
    set_op(MEM_NONE, 32'h0, 32'h0, 5'd8, 1'b1);
    check("fl_reqdrop", 32'(dbus_req_o), 32'd0);
    dbus_ack_i   = 1'b1;
    dbus_rdata_i = 32'hDEAD_BEEF;
    step();
    dbus_ack_i = 1'b0;
    check("fl_late_req", 32'(dbus_req_o), 32'd0);
    check("fl_late_wdata", wdata_o, 32'h5555_AAAA);
    check("fl_late_stall", 32'(stall_req_o), 32'd0);

    // Reset mid-REQ
    set_op(MEM_LW, 32'h600, 32'h0, 5'd6, 1'b1);
    step();
    check("rr_req", 32'(dbus_req_o), 32'd1);
    rst = 1'b0;
    #1;
    check("rr_reqdrop", 32'(dbus_req_o), 32'd0);
    check("rr_rw", 32'(rw_o), 32'd0);
    check("rr_stall", 32'(stall_req_o), 32'd0);
    check("rr_addr", dbus_addr_o, 32'h0);
    step();
    set_op(MEM_NONE, 32'h0, 32'h0, 5'd11, 1'b1);
    rst = 1'b1;
    dbus_ack_i = 1'b1;
    step();
    dbus_ack_i = 1'b0;
    check("rr_idle_rw", 32'(rw_o), 32'd11);
    check("rr_idle_req", 32'(dbus_req_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM pipeline stage sitting between the ex_mem pipeline register and mem_wb.
- Executes MIPS load/store over a request/acknowledge data bus and formats load data (big-endian lanes, sign/zero extension).
- Stalls the pipeline while an access is outstanding.
- Non-memory instructions pass rw/wreg/wdata straight through to mem_wb.

Parameters:
ACK_TIMEOUT, 16, max cycles in REQ waiting for dbus_ack_i before abort with bus error
TO_W, 5, width of timeout counter; must satisfy 2^TO_W > ACK_TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
flush_i  in  1  pipeline flush; aborts any access
rw_i  in  5  destination register from ex_mem
wreg_i  in  1  register write enable from ex_mem
wdata_i  in  32  ALU result from ex_mem
memop_i  in  4  memory op code (`MEM_NONE/LB/LBU/LH/LHU/LW/SB/SH/SW)
maddr_i  in  32  effective address
sdata_i  in  32  store data (rt), right-justified
rw_o  out  5  to mem_wb
wreg_o  out  1  to mem_wb
wdata_o  out  32  to mem_wb
stall_req_o  out  1  stall request to pipeline control
excpt_o  out  1  address misalignment (combinational)
bus_err_o  out  1  ack timeout, valid in DONE
dbus_req_o  out  1  bus request, registered
dbus_we_o  out  1  1=write, registered
dbus_addr_o  out  32  word address {maddr_i[31:2],2'b00}, registered
dbus_sel_o  out  4  byte lane enables, bit3=bits31:24, registered
dbus_wdata_o  out  32  lane-replicated store data, registered
dbus_ack_i  in  1  access complete; rdata valid same cycle
dbus_rdata_i  in  32  read data

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; dbus_req_o=0, dbus_we_o=0, dbus_addr_o=0, dbus_sel_o=0, dbus_wdata_o=0, load-data reg=0, bus_err reg=0, timeout counter=0.
- Combinational outputs during reset: rw_o=`NOPRegAddr, wreg_o=0, wdata_o=0, stall_req_o=0, excpt_o=0.
- Upstream holds all *_i stable while stall_req_o=1.
- Misalignment: LH/LHU/SH with addr[0]!=0; LW/SW with addr[1:0]!=0.
  - excpt_o=1, wreg_o=0, no bus access, stall_req_o=0.
- IDLE:
  - non-mem op: rw_o=rw_i, wreg_o=wreg_i, wdata_o=wdata_i, stall_req_o=0.
  - aligned mem op: stall_req_o=1; at the next edge, load dbus_* registers, assert dbus_req_o, go REQ.
- REQ:
  - stall_req_o=1; dbus_req_o held at 1.
  - At an edge with dbus_ack_i=1: capture formatted load data, drop req, go DONE.
  - Counter increments each REQ cycle. On reaching ACK_TIMEOUT without ack: drop req, set bus_err, go DONE.
- DONE:
  - stall_req_o=0; rw_o=rw_i.
  - wreg_o = wreg_i & is_load & ~bus_err.
  - wdata_o = load-data reg for loads.
  - Next edge unconditionally returns to IDLE, clears bus_err and the counter. Prevents re-issue of the same instruction.
- Latency: ack present on first REQ edge → 2 stall cycles; each extra wait cycle adds 1.
- Stores never write the register file (wreg_o=0).
- Load formatting, big-endian:
  - byte lane k = addr[1:0] → bits [31-8k:24-8k].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - half at addr[1]=0 → bits31:16.
- Store steering: SB replicates the byte to all lanes, sel=4'b1000>>addr[1:0]; SH replicates the half, sel=1100/0011; SW sel=1111.
- flush_i=1 in any state: next edge → IDLE, dbus_req_o=0, counter/bus_err cleared; stall_req_o forced 0 that cycle. Priority over ack and timeout.
- dbus_ack_i in IDLE/DONE is ignored.

Decomposition:
- defines.v gets `MEM_* op codes (4-bit), `MemOpBus, and state encodings (IDLE/REQ/DONE).
- Sub-module mem_align (combinational): load extraction/extension and store lane steering/sel generation. FSM and timeout stay in mem_access.

Test Plan:
- ADD passthrough, rw_i=5'd3, wreg_i=1, wdata_i=32'h1234 → same cycle rw_o=3, wreg_o=1, wdata_o=32'h1234, stall_req_o=0, dbus_req_o stays 0.
- LB addr=32'h103, ack on first REQ edge, rdata=32'h112233F0 → dbus_sel_o=4'b0001, stall 2 cycles, DONE wdata_o=32'hFFFFFFF0, wreg_o=1; LBU same → 32'h000000F0.
- SH addr=32'h202, sdata=32'hABCD, ack after 3 wait cycles → dbus_we_o=1, sel=4'b0011, wdata=32'hABCDABCD, stall 5 cycles, wreg_o=0.
- LW addr=32'h101 → excpt_o=1, wreg_o=0, no dbus_req_o, stall_req_o=0.
- LW, ack never arrives, ACK_TIMEOUT=16 → req high 16 cycles then DONE with bus_err_o=1, wreg_o=0, IDLE next cycle.
- LW in REQ, flush_i pulse (and separately rst low mid-REQ) → req drops at next edge / immediately on reset, state IDLE, late ack ignored.
